// File: rtl/adc_uart_sched.sv
// Round-robin scheduler feeding requester bytes to a single UART transmitter.
// Define SCHED_HEADER_EN to precede each data byte with header 8'hA0|grant_id.
module adc_uart_sched #(
    parameter int NUM_REQ = 4,
    parameter int TMO_CYC = 1000
) (
    input  logic                 RST_clk,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_byte,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 err_tmo
);

    localparam int CW = $clog2(TMO_CYC + 1);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        HDR,
        DATA,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [7:0]    byte_q, byte_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ret_q, ret_d;
    logic          err_q, err_d;
    logic [2:0]    pick;
    logic          found;
    logic [3:0]    idx;

    // Walk from the farthest candidate back to the nearest so the
    // closest pending requester after the last grant wins.
    always_comb begin
        pick  = grant_q;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 4'(grant_q) + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (req[idx[IW-1:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        ret_d    = ret_q;
        err_d    = err_q;
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        ack      = '0;
        unique case (state_q)
            IDLE: begin
                if (|req && !tx_busy) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (found) begin
                    grant_d = pick;
                    byte_d  = req_data[8*pick +: 8];
`ifdef SCHED_HEADER_EN
                    state_d = HDR;
`else
                    state_d = DATA;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                tx_byte = 8'hA0 | {5'd0, grant_q};
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    cnt_d    = '0;
                    ret_d    = 1'b1;
                    state_d  = WAIT_HI;
                end
            end
            DATA: begin
                tx_byte = byte_q;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    ack      = req & (NUM_REQ'(1) << grant_q);
                    cnt_d    = '0;
                    ret_d    = 1'b0;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CW'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ret_q ? DATA : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge RST_clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= 3'(NUM_REQ - 1);
            byte_q  <= 8'h00;
            cnt_q   <= '0;
            ret_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
        end
    end

    assign grant_id = grant_q;
    assign err_tmo  = err_q;

endmodule

// File: tb/tb_adc_uart_sched.sv
// Bench for adc_uart_sched: vector table, corner sequences, random traffic.
// UART busy is a behavioural model; grants checked against round-robin rule.
module tb_adc_uart_sched;

    localparam int NR  = 4;
    localparam int TMO = 20;

    logic          RST_clk  = 1'b0;
    logic          RST      = 1'b1;
    logic [NR-1:0] req      = '0;
    logic [31:0]   req_data = '0;
    logic [NR-1:0] ack;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_busy  = 1'b0;
    logic [2:0]    grant_id;
    logic          err_tmo;

    int errors = 0;
    int checks = 0;
    int busy_len = 10;
    bit busy_en = 1'b1;
    int busy_cnt = 0;
    bit pend = 1'b0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] exp_first;
        logic [3:0] exp_ack;
    } vec_t;

    adc_uart_sched #(.NUM_REQ(NR), .TMO_CYC(TMO)) dut (
        .RST_clk (RST_clk),
        .RST     (RST),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .tx_byte (tx_byte),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .grant_id(grant_id),
        .err_tmo (err_tmo)
    );

    always #5 RST_clk = ~RST_clk;

    // UART model: busy rises the cycle after a start and stays busy_len cycles
    always @(negedge RST_clk) begin
        if (RST) begin
            busy_cnt = 0;
            pend = 1'b0;
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (pend) busy_cnt = busy_len;
            pend = busy_en && tx_start;
        end
        tx_busy = (busy_cnt != 0);
    end

    always @(negedge RST_clk) begin
        #2;
        if (!RST) begin
            checks++;
            if ($countones(ack) > 1 || (ack & ~req) != 0 ||
                (tx_start && tx_busy)) begin
                errors++;
                $display("FAIL protocol: ack=%b req=%b tx_start=%b tx_busy=%b (need onehot ack within req, no start while busy)",
                         ack, req, tx_start, tx_busy);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (last + k) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [7:0] first_byte(input int i, input logic [7:0] d);
`ifdef SCHED_HEADER_EN
        return 8'hA0 | 8'(i);
`else
        return d;
`endif
    endfunction

    function automatic logic [3:0] first_ack(input int i);
`ifdef SCHED_HEADER_EN
        return 4'(0 * i);
`else
        return 4'(1) << i;
`endif
    endfunction

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge RST_clk);
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge RST_clk);
            if (ack != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (25) begin
            @(negedge RST_clk);
            if (ack != 0) n++;
        end
        check({tag, "_extra_ack"}, n, 0);
    endtask

    task automatic pulse_reset(input string tag);
        #3 RST = 1'b1;
        #1;
        check({tag, "_ack"}, ack, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_byte"}, tx_byte, 0);
        check({tag, "_grant_id"}, grant_id, NR - 1);
        check({tag, "_err_tmo"}, err_tmo, 0);
        @(negedge RST_clk);
        #1 RST = 1'b0;
    endtask

    initial begin
        vec_t       tbl[5];
        bit         ok;
        int         n;
        int         g;
        int         last_g;
        int         nacks;
        int         ord[5];
        logic [7:0] dat[NR];
`ifdef SCHED_HEADER_EN
        bit         hdr_seen;
        int         pend_g;
`endif

        tbl[0] = '{0, 8'h55, first_byte(0, 8'h55), first_ack(0)};
        tbl[1] = '{1, 8'hAA, first_byte(1, 8'hAA), first_ack(1)};
        tbl[2] = '{1, 8'h0F, first_byte(1, 8'h0F), first_ack(1)};
        tbl[3] = '{3, 8'hFF, first_byte(3, 8'hFF), first_ack(3)};
        tbl[4] = '{2, 8'h00, first_byte(2, 8'h00), first_ack(2)};
        ord = '{0, 1, 2, 3, 0};

        @(negedge RST_clk);
        pulse_reset("reset");
        @(negedge RST_clk);
        check("post_reset_start", tx_start, 0);
        check("post_reset_grant", grant_id, NR - 1);

        // all requesters held high: strict rotation
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack(200, ok);
            check("rr_ack_seen", ok, 1);
            check("rr_ack_order", ack, 4'(1) << ord[k]);
            check("rr_byte", tx_byte, 8'h11 * (ord[k] + 1));
        end
        req = '0;
        wait_idle("rr");

        for (int t = 0; t < 5; t++) begin
            @(negedge RST_clk);
            req_data[8*tbl[t].idx +: 8] = tbl[t].data;
            req = 4'(1) << tbl[t].idx;
            @(negedge RST_clk);
            check("tbl_lat1_start", tx_start, 0);
            @(negedge RST_clk);
            check("tbl_lat2_start", tx_start, 1);
            check("tbl_byte", tx_byte, tbl[t].exp_first);
            check("tbl_ack", ack, tbl[t].exp_ack);
            check("tbl_grant", grant_id, tbl[t].idx);
`ifdef SCHED_HEADER_EN
            wait_ack(60, ok);
            check("tbl_hdr_data_seen", ok, 1);
            check("tbl_hdr_data_byte", tx_byte, tbl[t].data);
`endif
            req = '0;
            wait_idle("tbl");
        end

        // transmitter never goes busy: timeout
        busy_en = 1'b0;
        @(negedge RST_clk);
        req_data[15:8] = 8'h77;
        req = 4'b0010;
        wait_start(10, ok);
        check("tmo_start_seen", ok, 1);
        check("tmo_first_ack", ack, first_ack(1));
        check("tmo_first_byte", tx_byte, first_byte(1, 8'h77));
        req = '0;
        n = 0;
        repeat (TMO) begin
            @(negedge RST_clk);
            if (ack != 0) n++;
        end
        check("tmo_err_early", err_tmo, 0);
        @(negedge RST_clk);
        check("tmo_err_set", err_tmo, 1);
        check("tmo_no_ack", n, 0);
        n = 0;
        repeat (3) begin
            @(negedge RST_clk);
            if (tx_start) n++;
        end
        check("tmo_idle_quiet", n, 0);
        busy_en = 1'b1;
        req_data[15:8] = 8'h78;
        req = 4'b0010;
        @(negedge RST_clk);
        check("tmo_recover_lat1", tx_start, 0);
        @(negedge RST_clk);
        check("tmo_recover_lat2", tx_start, 1);
        check("tmo_recover_ack", ack, first_ack(1));
`ifdef SCHED_HEADER_EN
        wait_ack(60, ok);
        check("tmo_recover_data", ok, 1);
`endif
        req = '0;
        wait_idle("tmo");
        check("tmo_sticky", err_tmo, 1);

        // reset while waiting for busy to fall
        busy_len = 10;
        @(negedge RST_clk);
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        wait_start(10, ok);
        check("wlo_start_seen", ok, 1);
        check("wlo_first_byte", tx_byte, first_byte(2, 8'h3C));
        req = '0;
        n = 0;
        while (!tx_busy && n < 10) begin
            @(negedge RST_clk);
            n++;
        end
        check("wlo_busy_seen", tx_busy, 1);
        repeat (3) @(negedge RST_clk);
        pulse_reset("wlo_reset");
        req_data[7:0] = 8'h11;
        req_data[31:24] = 8'h33;
        req = 4'b1001;
        wait_start(10, ok);
        check("wlo_regrant_seen", ok, 1);
        check("wlo_regrant_id", grant_id, 0);
        check("wlo_regrant_byte", tx_byte, first_byte(0, 8'h11));
        check("wlo_regrant_ack", ack, first_ack(0));
        req = '0;
        wait_idle("wlo");

        // random traffic against the round-robin rule
        @(negedge RST_clk);
        pulse_reset("rand_reset");
        last_g = NR - 1;
        nacks = 0;
        for (int i = 0; i < NR; i++) dat[i] = 8'h00;
`ifdef SCHED_HEADER_EN
        hdr_seen = 1'b0;
        pend_g = 0;
`endif
        for (int it = 0; it < 2500; it++) begin
            @(negedge RST_clk);
            g = -1;
            if (tx_start) begin
                busy_len = $urandom_range(1, 6);
`ifdef SCHED_HEADER_EN
                if (!hdr_seen) begin
                    pend_g = rr_pick(req, last_g);
                    check("rand_hdr_byte", tx_byte, 8'hA0 | 8'(pend_g));
                    check("rand_hdr_ack", ack, 0);
                    hdr_seen = 1'b1;
                end else begin
                    g = pend_g;
                    check("rand_ack", ack, 4'(1) << g);
                    check("rand_byte", tx_byte, dat[g]);
                    hdr_seen = 1'b0;
                end
`else
                g = rr_pick(req, last_g);
                check("rand_grant", grant_id, g);
                check("rand_ack", ack, 4'(1) << g);
                check("rand_byte", tx_byte, dat[g]);
`endif
                if (g >= 0) begin
                    last_g = g;
                    req[g] = 1'b0;
                    nacks++;
                end
            end else begin
                check("rand_stray_ack", ack, 0);
            end
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && i != g && $urandom_range(0, 3) == 0) begin
                    dat[i] = 8'($urandom);
                    req_data[8*i +: 8] = dat[i];
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (40) @(negedge RST_clk);
        check("rand_enough_grants", nacks >= 40, 1);
        check("rand_no_timeout", err_tmo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
